// File: rtl/tug_of_war_field.sv
// Tug-of-war playfield: a light is pulled left/right by button presses.
// Tracks round wins per side and freezes once a side reaches WIN_SCORE.
module tug_of_war_field #(
  parameter int NUM_LIGHTS = 9,
  parameter int SCORE_W    = 3,
  parameter int WIN_SCORE  = 7
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  L,
  input  logic                  R,
  output logic [NUM_LIGHTS-1:0] lights,
  output logic                  winL,
  output logic                  winR,
  output logic [SCORE_W-1:0]    scoreL,
  output logic [SCORE_W-1:0]    scoreR,
  output logic                  gameOver
);

  localparam int PW = $clog2(NUM_LIGHTS);
  localparam logic [PW-1:0] CTR  = PW'((NUM_LIGHTS - 1) / 2);
  localparam logic [PW-1:0] MAXP = PW'(NUM_LIGHTS - 1);
  localparam logic [SCORE_W-1:0] WINS = SCORE_W'(WIN_SCORE);
  localparam logic [NUM_LIGHTS-1:0] ONE = NUM_LIGHTS'(1);

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    WIN_L = 2'd1,
    WIN_R = 2'd2,
    OVER  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      pos_q, pos_d;
  logic [SCORE_W-1:0] scl_q, scl_d;
  logic [SCORE_W-1:0] scr_q, scr_d;
  logic               lprev_q, rprev_q;
  logic               pressl_q, pressr_q;

  // Rising-edge press detect; reset loads current levels so held buttons stay quiet
  always_ff @(posedge Clock) begin
    if (Reset) begin
      lprev_q  <= L;
      rprev_q  <= R;
      pressl_q <= 1'b0;
      pressr_q <= 1'b0;
    end else begin
      lprev_q  <= L;
      rprev_q  <= R;
      pressl_q <= L & ~lprev_q;
      pressr_q <= R & ~rprev_q;
    end
  end

  // Game state, light position and scores
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= PLAY;
      pos_q   <= CTR;
      scl_q   <= '0;
      scr_q   <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      scl_q   <= scl_d;
      scr_q   <= scr_d;
    end
  end

  // Next-state and Moore outputs
  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    scl_d    = scl_q;
    scr_d    = scr_q;
    lights   = '0;
    winL     = 1'b0;
    winR     = 1'b0;
    gameOver = 1'b0;
    unique case (state_q)
      PLAY: begin
        lights = ONE << pos_q;
        if (pos_q > MAXP) begin
          pos_d = CTR;
        end else if (pressl_q && !pressr_q) begin
          if (pos_q == MAXP) begin
            state_d = WIN_L;
            scl_d   = scl_q + 1'b1;
          end else begin
            pos_d = pos_q + 1'b1;
          end
        end else if (pressr_q && !pressl_q) begin
          if (pos_q == '0) begin
            state_d = WIN_R;
            scr_d   = scr_q + 1'b1;
          end else begin
            pos_d = pos_q - 1'b1;
          end
        end
      end
      WIN_L: begin
        winL = 1'b1;
        if (scl_q == WINS) begin
          state_d = OVER;
        end else begin
          state_d = PLAY;
          pos_d   = CTR;
        end
      end
      WIN_R: begin
        winR = 1'b1;
        if (scr_q == WINS) begin
          state_d = OVER;
        end else begin
          state_d = PLAY;
          pos_d   = CTR;
        end
      end
      OVER: begin
        lights   = '1;
        gameOver = 1'b1;
      end
      default: begin
        state_d = PLAY;
        pos_d   = CTR;
      end
    endcase
  end

  assign scoreL = scl_q;
  assign scoreR = scr_q;

endmodule

// File: tb/tb_tug_of_war_field.sv
// Bench for tug_of_war_field: directed scenarios with literal values
// plus randomized play checked every cycle against a behavioural model.
module tb_tug_of_war_field;

  localparam int N  = 9;
  localparam int SW = 3;
  localparam int WS = 7;
  localparam int C  = (N - 1) / 2;

  logic         Clock = 1'b0;
  logic         Reset = 1'b0;
  logic         L = 1'b0;
  logic         R = 1'b0;
  logic [N-1:0] lights;
  logic         winL, winR, gameOver;
  logic [SW-1:0] scoreL, scoreR;

  int tests = 0;
  int fails = 0;

  tug_of_war_field #(
    .NUM_LIGHTS(N), .SCORE_W(SW), .WIN_SCORE(WS)
  ) dut (
    .Clock(Clock), .Reset(Reset), .L(L), .R(R),
    .lights(lights), .winL(winL), .winR(winR),
    .scoreL(scoreL), .scoreR(scoreR), .gameOver(gameOver)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0=play 1=left took round 2=right took round 3=over
  int  m_mode = 0;
  int  m_pos = C;
  int  m_sl = 0;
  int  m_sr = 0;
  bit  m_pendL = 0, m_pendR = 0;
  bit  m_lastL = 0, m_lastR = 0;
  bit  m_valid = 0;

  always @(posedge Clock) begin
    if (Reset) begin
      m_mode <= 0; m_pos <= C; m_sl <= 0; m_sr <= 0;
      m_pendL <= 0; m_pendR <= 0;
      m_lastL <= L; m_lastR <= R;
      m_valid <= 1;
    end else begin
      m_pendL <= L && !m_lastL;
      m_pendR <= R && !m_lastR;
      m_lastL <= L;
      m_lastR <= R;
      if (m_mode == 0) begin
        if (m_pendL && !m_pendR) begin
          if (m_pos == N - 1) begin
            m_mode <= 1; m_sl <= m_sl + 1;
          end else m_pos <= m_pos + 1;
        end else if (m_pendR && !m_pendL) begin
          if (m_pos == 0) begin
            m_mode <= 2; m_sr <= m_sr + 1;
          end else m_pos <= m_pos - 1;
        end
      end else if (m_mode == 1) begin
        if (m_sl == WS) m_mode <= 3;
        else begin m_mode <= 0; m_pos <= C; end
      end else if (m_mode == 2) begin
        if (m_sr == WS) m_mode <= 3;
        else begin m_mode <= 0; m_pos <= C; end
      end
    end
  end

  function automatic int exp_lights();
    if (m_mode == 0) return 1 << m_pos;
    if (m_mode == 3) return (1 << N) - 1;
    return 0;
  endfunction

  // Every-cycle comparison against the model
  always @(negedge Clock) begin
    if (m_valid) begin
      chk("m_lights", int'(lights), exp_lights());
      chk("m_winL", int'(winL), int'(m_mode == 1));
      chk("m_winR", int'(winR), int'(m_mode == 2));
      chk("m_over", int'(gameOver), int'(m_mode == 3));
      chk("m_scoreL", int'(scoreL), m_sl);
      chk("m_scoreR", int'(scoreR), m_sr);
    end
  end

  task automatic do_reset();
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    #1;
  endtask

  task automatic pulse(input bit pl, input bit pr);
    L = pl; R = pr;
    @(negedge Clock);
    L = 1'b0; R = 1'b0;
    @(negedge Clock);
    #1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge Clock);
    #1;
  endtask

  int exp4[4] = '{32'h020, 32'h040, 32'h080, 32'h100};

  initial begin
    do_reset();
    chk("rst_lights", int'(lights), 32'h010);
    chk("rst_scores", int'({scoreL, scoreR}), 0);
    chk("rst_flags", int'({winL, winR, gameOver}), 0);

    for (int i = 0; i < 4; i++) begin
      pulse(1, 0);
      chk($sformatf("walk%0d", i), int'(lights), exp4[i]);
    end
    pulse(1, 0);
    chk("winL_pulse", int'(winL), 1);
    chk("winL_lights", int'(lights), 0);
    chk("winL_score", int'(scoreL), 1);
    tick(1);
    chk("winL_gone", int'(winL), 0);
    chk("after_win", int'(lights), 32'h010);

    L = 1'b1;
    tick(20);
    L = 1'b0;
    tick(2);
    chk("held_L", int'(lights), 32'h020);
    pulse(0, 1);
    chk("back_ctr", int'(lights), 32'h010);

    pulse(1, 1);
    tick(1);
    chk("both_lights", int'(lights), 32'h010);
    chk("both_score", int'({scoreL, scoreR}), int'({3'd1, 3'd0}));

    do_reset();
    for (int rnd = 0; rnd < 7; rnd++) begin
      for (int k = 0; k < 5; k++) pulse(0, 1);
      chk($sformatf("winR_%0d", rnd), int'(winR), 1);
    end
    tick(1);
    chk("over_flag", int'(gameOver), 1);
    chk("over_lights", int'(lights), 32'h1FF);
    chk("over_scoreR", int'(scoreR), 7);
    pulse(1, 0);
    pulse(0, 1);
    pulse(1, 0);
    chk("over_frozen", int'({scoreL, scoreR, gameOver}), int'({3'd0, 3'd7, 1'b1}));
    chk("over_lights2", int'(lights), 32'h1FF);

    do_reset();
    for (int k = 0; k < 5; k++) pulse(0, 1);
    chk("pre_rst_winR", int'(winR), 1);
    R = 1'b1;
    Reset = 1'b1;
    tick(1);
    Reset = 1'b0;
    chk("midwin_lights", int'(lights), 32'h010);
    chk("midwin_winR", int'(winR), 0);
    chk("midwin_scores", int'({scoreL, scoreR}), 0);
    tick(3);
    R = 1'b0;
    tick(3);
    chk("held_R_rst", int'(lights), 32'h010);

    for (int ph = 0; ph < 20; ph++) begin
      int biasL = $urandom_range(0, 100);
      for (int c = 0; c < 200; c++) begin
        @(negedge Clock);
        L = ($urandom_range(0, 99) < biasL) ? ~L : L;
        R = ($urandom_range(0, 99) < (100 - biasL)) ? ~R : R;
        if ($urandom_range(0, 99) < 60) begin
          L = ($urandom_range(0, 99) < biasL);
          R = ($urandom_range(0, 99) >= biasL);
        end
        Reset = ($urandom_range(0, 599) == 0);
      end
    end
    Reset = 1'b0;
    L = 1'b0;
    R = 1'b0;
    tick(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tug_of_war_field.md
TUG_OF_WAR_FIELD -- requirements
Module: tug_of_war_field

Interface
REQ-001 SHALL have parameter NUM_LIGHTS, default 9; odd, >= 3. Number of playfield lights; centre index C = (NUM_LIGHTS-1)/2.
REQ-002 SHALL have parameter SCORE_W, default 3. Width of each score counter.
REQ-003 SHALL have parameter WIN_SCORE, default 7. Round wins needed to end the match; 1 <= WIN_SCORE <= 2^SCORE_W-1.
REQ-004 SHALL have port Clock, input, 1 bit. Single clock; all state updates on its rising edge.
REQ-005 SHALL have port Reset, input, 1 bit. Synchronous, active-high.
REQ-006 SHALL have port L, input, 1 bit. Left player button, raw level, already synchronised to Clock.
REQ-007 SHALL have port R, input, 1 bit. Right player button, raw level, already synchronised to Clock.
REQ-008 SHALL have port lights, output, NUM_LIGHTS bits. One-hot playfield; bit 0 = rightmost, bit NUM_LIGHTS-1 = leftmost.
REQ-009 SHALL have port winL, output, 1 bit. High for exactly one cycle when the left player takes a round.
REQ-010 SHALL have port winR, output, 1 bit. High for exactly one cycle when the right player takes a round.
REQ-011 SHALL have port scoreL, output, SCORE_W bits. Left round count.
REQ-012 SHALL have port scoreR, output, SCORE_W bits. Right round count.
REQ-013 SHALL have port gameOver, output, 1 bit. High while the match is finished.

Function
REQ-014 Press detection SHALL be registered: pressL = L & ~L_prev, pressR = R & ~R_prev; L_prev/R_prev sample L/R every cycle.
REQ-015 A held button SHALL produce one press only; re-press requires L (or R) low for >= 1 cycle.
REQ-016 State machine SHALL have states PLAY, WIN_L, WIN_R, OVER, plus position register pos (0..NUM_LIGHTS-1).
REQ-017 In PLAY, lights SHALL equal one-hot(pos); winL = winR = gameOver = 0.
REQ-018 In PLAY, pressL only with pos < NUM_LIGHTS-1: pos <= pos+1 (light moves left).
REQ-019 In PLAY, pressR only with pos > 0: pos <= pos-1 (light moves right).
REQ-020 In PLAY, pressL only with pos = NUM_LIGHTS-1: next state WIN_L; scoreL <= scoreL+1.
REQ-021 In PLAY, pressR only with pos = 0: next state WIN_R; scoreR <= scoreR+1.
REQ-022 Simultaneous pressL and pressR, or no press, SHALL leave pos and state unchanged.
REQ-023 Latency: press sampled at edge k SHALL be visible on lights/score/state outputs after edge k+1 (one register stage for edge detect, one for state).
REQ-024 WIN_L/WIN_R SHALL last exactly one cycle: lights = 0, winL (resp. winR) = 1, and presses are ignored.
REQ-025 From WIN_x, if the incremented score = WIN_SCORE, next state SHALL be OVER; otherwise PLAY with pos <= C.
REQ-026 In OVER, lights SHALL be all ones, gameOver = 1, win flags 0, scores frozen, and all presses ignored until Reset.
REQ-027 Score counters SHALL never wrap; increment occurs only in the PLAY->WIN_x transition.
REQ-028 Unreachable state encodings SHALL recover to PLAY with pos = C on the next edge.

Reset
REQ-029 Reset high at an edge SHALL force state PLAY, pos = C, scoreL = scoreR = 0, and gameOver = winL = winR = 0, regardless of current state (including mid-WIN and OVER).
REQ-030 During Reset, L_prev/R_prev SHALL load current L/R, so buttons held through reset release generate no press.
REQ-031 After reset, lights SHALL equal one-hot(C) (bit 4 for defaults) on the first cycle.

Verification (defaults NUM_LIGHTS=9, WIN_SCORE=7)
REQ-032 Reset, then 4 separate L pulses -> lights 0x020, 0x040, 0x080, 0x100 in turn; 5th L pulse -> winL one cycle, lights 0, scoreL = 1, then lights 0x010.
REQ-033 L held high for 20 cycles -> exactly one move (0x010 -> 0x020).
REQ-034 L and R rise in the same cycle at centre -> lights stay 0x010 and no score change.
REQ-035 Right wins 7 rounds -> 7th winR pulse followed by gameOver = 1, lights 0x1FF, scoreR = 7; further L/R pulses change nothing.
REQ-036 Reset asserted during WIN_R cycle while R held -> next cycle PLAY, lights 0x010, scores 0, winR = 0, and no press from held R after release of Reset.
